// File: rtl/dual_edge_lane_pkg.sv
// Shared types and helpers for the dual-edge lane arbiter.
//   lane_arb_state_e : sequencer states (IDLE, GAP, XFER)
//   MAX_REQ/MAX_IDX_W: upper bound on requesters and owner index width
//   owner_w()        : owner index width for a given requester count
//   rr_pick()        : round-robin winner search, first valid at/after ptr
package dual_edge_lane_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    XFER = 2'd2
  } lane_arb_state_e;

  function automatic int owner_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // valid is zero-extended to MAX_REQ; only the first num_req bits are searched.
  // Returns 0 when nothing is valid; callers qualify with their own any-valid.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                 input int                 ptr,
                                 input int                 num_req);
    int  win;
    int  idx;
    bit  found;
    win   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < num_req) begin
        idx = ptr + i;
        if (idx >= num_req) idx = idx - num_req;
        if (!found && valid[idx[MAX_IDX_W-1:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dual_edge_lane_arb_rr_arbiter.sv
// Round-robin arbiter: combinational pick plus registered priority pointer.
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   valid_i      : per-requester request
//   adv_i        : advance pointer past adv_idx_i this cycle
//   adv_idx_i    : index of the requester just served
//   any_o        : at least one request present
//   grant_idx_o  : first requester at or after the pointer, wrapping
module dual_edge_lane_arb_rr_arbiter
  import dual_edge_lane_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               adv_i,
  input  logic [IDX_W-1:0]   adv_idx_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid_i;
    any_o                    = |valid_i;
    grant_idx_o              = IDX_W'(rr_pick(valid_ext, int'(ptr_q), NUM_REQ));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      if (adv_idx_i == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                  ptr_d = adv_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dual_edge_lane_arb.sv
// Shares one dual-edge lane register between NUM_REQ packet requesters.
// One requester is granted per packet; its words are forwarded to the lane
// register enable/data one cycle after each valid/ready handshake. GAP_CYCLES
// idle cycles are inserted when ownership changes.
// Optional watchdog: define DUAL_EDGE_LANE_ARB_WATCHDOG_EN to abort a packet
// after TIMEOUT consecutive stall cycles (error_o pulses); otherwise error_o=0.
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters
// GAP   | turnaround after an ownership change, lane idle
// XFER  | owner streams words until last
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_valid_i  : per-requester word valid
//   req_last_i   : per-requester last word of packet
//   req_data_i   : requester k word at [k*WIDTH +: WIDTH]
//   req_ready_o  : per-requester accept, one-hot or zero
//   lane_en_o    : lane register enable
//   lane_data_o  : lane register data (holds when lane_en_o=0)
//   owner_o      : current or last granted requester
//   busy_o       : packet in progress (GAP or XFER)
//   error_o      : watchdog abort pulse
module dual_edge_lane_arb
  import dual_edge_lane_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       lane_en_o,
  output logic [WIDTH-1:0]           lane_data_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       busy_o,
  output logic                       error_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = 4;

  lane_arb_state_e  state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             lane_en_q, lane_en_d;
  logic [WIDTH-1:0] lane_data_q, lane_data_d;

  logic             arb_any;
  logic [IDX_W-1:0] arb_idx;
  logic             adv;

  logic [WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data_i[g*WIDTH +: WIDTH];
  end

  dual_edge_lane_arb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (req_valid_i),
    .adv_i       (adv),
    .adv_idx_i   (owner_q),
    .any_o       (arb_any),
    .grant_idx_o (arb_idx)
  );

`ifdef DUAL_EDGE_LANE_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            error_q, error_d;
  logic            wd_expire;

  // Counts consecutive owner stall cycles in XFER; any transfer clears it.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == XFER && !req_valid_i[owner_q]) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  assign wd_expire = (state_q == XFER) && !req_valid_i[owner_q] &&
                     (wd_cnt_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error_o = error_q;
`else
  logic wd_expire;
  assign wd_expire = 1'b0;
  // TIMEOUT only matters with the watchdog; this evaluates to a constant 0.
  assign error_o   = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    gap_cnt_d   = gap_cnt_q;
    lane_en_d   = 1'b0;
    lane_data_d = lane_data_q;
    adv         = 1'b0;
    req_ready_o = '0;
`ifdef DUAL_EDGE_LANE_ARB_WATCHDOG_EN
    error_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          // Re-granting the previous owner needs no turnaround.
          if (arb_idx != owner_q && GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          end else begin
            state_d = XFER;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = XFER;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      XFER: begin
        req_ready_o[owner_q] = req_valid_i[owner_q];
        if (req_valid_i[owner_q]) begin
          lane_en_d   = 1'b1;
          lane_data_d = data_arr[owner_q];
          if (req_last_i[owner_q]) begin
            state_d = IDLE;
            adv     = 1'b1;
          end
        end else if (wd_expire) begin
          state_d = IDLE;
          adv     = 1'b1;
`ifdef DUAL_EDGE_LANE_ARB_WATCHDOG_EN
          error_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      gap_cnt_q   <= '0;
      lane_en_q   <= 1'b0;
      lane_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gap_cnt_q   <= gap_cnt_d;
      lane_en_q   <= lane_en_d;
      lane_data_q <= lane_data_d;
    end
  end

  assign lane_en_o   = lane_en_q;
  assign lane_data_o = lane_data_q;
  assign owner_o     = owner_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dual_edge_lane_arb.sv
module tb_dual_edge_lane_arb;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 1;
  localparam int TO  = 16;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i, req_last_i, req_ready_o;
  logic [N*W-1:0] req_data_i;
  logic           lane_en_o;
  logic [W-1:0]   lane_data_o;
  logic [1:0]     owner_o;
  logic           busy_o, error_o;

  dual_edge_lane_arb #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .lane_en_o   (lane_en_o),
    .lane_data_o (lane_data_o),
    .owner_o     (owner_o),
    .busy_o      (busy_o),
    .error_o     (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: per-requester word queues ({last,data}) and packet-level
  // round-robin bookkeeping.
  logic [W:0]   q[N][$];
  int           pkt_idx[N];
  logic [N-1:0] hold;
  int           ptr_m, last_own_m, cur_m, stall_m, last_beat_t, cyc, err_seen;
  logic [W-1:0] last_data_m;
  bit           rand_stall;
  int           st_r, st_after, st_len;
  int           own_seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    for (int i = 0; i < N; i++) begin
      int r;
      r = (ptr_m + i) % N;
      if (q[r].size() != 0) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = 0; last_own_m = 0; cur_m = -1; stall_m = 0;
    last_beat_t = -1; last_data_m = '0; hold = '0;
    for (int r = 0; r < N; r++) begin
      pkt_idx[r] = 0;
      q[r].delete();
    end
  endtask

  task automatic push(input int r, input logic [W-1:0] d, input bit l);
    q[r].push_back({l, d});
  endtask

  task automatic start_scn();
    last_beat_t = -1; rand_stall = 1'b0; st_r = -1; st_len = 0; st_after = 0;
  endtask

  task automatic cycle(input bit do_rst);
    logic [N-1:0] hs;
    logic [W:0]   w;
    int           hr;
    bit           exp_en, abort;
    @(negedge clk_i);
    rst_i = do_rst;
    for (int r = 0; r < N; r++) begin
      logic v;
      if (q[r].size() == 0)       v = 1'b0;
      else if (hold[r])           v = 1'b1;
      else if (pkt_idx[r] == 0)   v = 1'b1;
      else if (r == st_r && pkt_idx[r] == st_after && st_len > 0) begin
        v = 1'b0; st_len--;
      end
      else if (rand_stall && $urandom_range(0, 9) < 3) v = 1'b0;
      else                        v = 1'b1;
      req_valid_i[r] = v;
      if (v) begin
        req_data_i[r*W +: W] = q[r][0][W-1:0];
        req_last_i[r]        = q[r][0][W];
      end
    end
    #1;
    hs = req_valid_i & req_ready_o;
    chk("ready_without_valid", req_ready_o & ~req_valid_i, '0);
    chk("ready_onehot", ($countones(req_ready_o) <= 1), 1);
    exp_en = 1'b0;
    abort  = 1'b0;
    if (!do_rst) begin
      if (hs != '0) begin
        hr = 0;
        for (int r = N - 1; r >= 0; r--) if (hs[r]) hr = r;
        if (cur_m < 0) begin
          chk("grant_owner", hr, model_pick());
          if (last_beat_t >= 0)
            chk("turnaround", cyc - last_beat_t, (hr != last_own_m) ? 2 + GAP : 2);
          cur_m = hr;
        end else begin
          chk("hold_owner", hr, cur_m);
        end
        w = q[hr].pop_front();
        exp_en = 1'b1; last_data_m = w[W-1:0]; last_beat_t = cyc;
        pkt_idx[hr]++; stall_m = 0;
        if (w[W]) begin
          pkt_idx[hr] = 0; ptr_m = (hr + 1) % N; last_own_m = hr; cur_m = -1;
        end
      end else if (cur_m >= 0 && !req_valid_i[cur_m]) begin
`ifdef DUAL_EDGE_LANE_ARB_WATCHDOG_EN
        stall_m++;
        if (stall_m == TO) begin
          abort = 1'b1;
          while (q[cur_m].size() > 0) begin
            w = q[cur_m].pop_front();
            if (w[W]) break;
          end
          pkt_idx[cur_m] = 0; ptr_m = (cur_m + 1) % N; last_own_m = cur_m;
          cur_m = -1; stall_m = 0; last_beat_t = -1;
        end
`endif
      end
    end
    hold = req_valid_i & ~hs;
    @(posedge clk_i);
    #1;
    if (error_o === 1'b1) err_seen++;
    if (do_rst) begin
      model_reset();
      chk("rst_lane_en", lane_en_o, 0);
      chk("rst_lane_data", lane_data_o, 0);
      chk("rst_owner", owner_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_ready", req_ready_o, '0);
    end else begin
      chk("lane_en", lane_en_o, exp_en);
      chk("lane_data", lane_data_o, last_data_m);
      chk("error", error_o, abort);
      if (exp_en) own_seq.push_back(int'(owner_o));
      if (cur_m >= 0) begin
        chk("busy_mid", busy_o, 1);
        chk("owner_mid", owner_o, cur_m);
      end else if (exp_en || abort) begin
        chk("busy_end", busy_o, 0);
        chk("owner_end", owner_o, last_own_m);
      end
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int  n;
    bit  pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      pend = (cur_m >= 0);
      for (int r = 0; r < N; r++) if (q[r].size() != 0) pend = 1'b1;
      if (pend) begin cycle(1'b0); n++; end
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d cycles expected<%0d", n, budget);
    end
    repeat (3) cycle(1'b0);
  endtask

  initial begin
    int exp_seq[5];
    int n;
    exp_seq = '{0, 1, 2, 3, 0};
    rst_i = 1'b1; req_valid_i = '0; req_last_i = '0; req_data_i = '0;
    cyc = 0; err_seen = 0;
    model_reset();
    start_scn();

    // Reset held 3 cycles, then a 3-word packet from req0.
    repeat (3) cycle(1'b1);
    start_scn();
    push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
    drain(50);

    // Round-robin fairness with single-word packets from all requesters.
    cycle(1'b1);
    start_scn();
    own_seq.delete();
    push(0, 8'hA0, 1); push(0, 8'hA4, 1);
    push(1, 8'hA1, 1); push(2, 8'hA2, 1); push(3, 8'hA3, 1);
    drain(100);
    chk("fair_len", own_seq.size(), 5);
    for (int i = 0; i < 5 && i < own_seq.size(); i++) chk("fair_seq", own_seq[i], exp_seq[i]);

    // Same-owner re-grant: two 2-word packets from req2 only.
    start_scn();
    push(2, 8'h21, 0); push(2, 8'h22, 1);
    push(2, 8'h23, 0); push(2, 8'h24, 1);
    drain(50);

    // Stall hold: req1 stalls 5 cycles after word 2 while req3 waits.
    cycle(1'b1);
    start_scn();
    push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 0); push(1, 8'h54, 1);
    push(3, 8'h7E, 1);
    st_r = 1; st_after = 2; st_len = 5;
    drain(100);

    // Reset mid-packet after word 1 of a 4-word packet from req1.
    start_scn();
    push(1, 8'h61, 0); push(1, 8'h62, 0); push(1, 8'h63, 0); push(1, 8'h64, 1);
    n = 0;
    while (pkt_idx[1] < 1 && n < 20) begin cycle(1'b0); n++; end
    chk("rst_mid_word1_seen", pkt_idx[1], 1);
    cycle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      chk("rst_mid_no_ready", req_ready_o[1], 0);
    end

`ifdef DUAL_EDGE_LANE_ARB_WATCHDOG_EN
    // Watchdog: req0 stalls TO cycles mid-packet; req1 must be granted next.
    cycle(1'b1);
    start_scn();
    err_seen = 0;
    push(0, 8'h01, 0); push(0, 8'h02, 0); push(0, 8'h03, 1);
    push(1, 8'h10, 1);
    st_r = 0; st_after = 1; st_len = TO;
    drain(200);
    chk("wd_pulse_count", err_seen, 1);
    chk("wd_next_owner", owner_o, 1);
`endif

    // Randomized packets with random mid-packet stalls.
    for (int round = 0; round < 6; round++) begin
      start_scn();
      rand_stall = 1'b1;
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          int npk;
          npk = $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++)
              push(r, W'($urandom_range(0, 255)), (k == len - 1));
          end
        end
      end
      drain(3000);
    end

`ifndef DUAL_EDGE_LANE_ARB_WATCHDOG_EN
    chk("no_error_pulses", err_seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
